alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single registered ALU between NREQ requesters (req 0 = execute stage, req 1 = branch/AGU).
//  Picks one request per cycle, drives the ALU en/func3/cs/operand inputs, and returns the registered result to the winner.
//  A hold register keeps the result if the winner cannot take it, because the ALU clears its output when en=0.
//  Sits between the issue logic and the alu instance; one ALU op per cycle while responses are accepted.
// PARAMETERS
//  NREQ   2              number of requesters, 2..4
//  IDW    $clog2(NREQ)   width of requester id
// PORTS
//  clk           in   1                      clock, all state on rising edge
//  rst           in   1                      asynchronous, active-high reset
//  req_valid     in   NREQ                   request i present
//  req_ready     out  NREQ                   request i granted this cycle; one-hot or zero
//  req_func3     in   NREQ x 3               per-requester func3
//  req_cs        in   NREQ x control_signals_t  per-requester control signals (sign, a used)
//  req_a, req_b  in   NREQ x 32              per-requester operands
//  alu_en        out  1                      to alu.en
//  alu_func3     out  3                      to alu.func3
//  alu_cs        out  control_signals_t      to alu.cs
//  alu_a, alu_b  out  32                     to alu operands
//  alu_result    in   32                     from alu (registered, 1-cycle latency)
//  rsp_valid     out  1                      response present
//  rsp_id        out  IDW                    requester owning the response
//  rsp_data      out  32                     result
//  rsp_zero      out  1                      rsp_data == 0
//  rsp_ready     in   1                      rsp_id owner accepts response
// BEHAVIOUR
//  - States
//    - IDLE: no result in flight.
//    - BUSY: the ALU output register holds the result issued last cycle.
//    - HOLD: the result sits in hold_q, waiting for rsp_ready.
//  - Reset values: state=IDLE, ptr=NREQ-1, rsp_valid=0, rsp_id=0, hold_q=0, alu_en=0, req_ready=0.
//  - Issue is allowed in IDLE, or in BUSY when rsp_ready=1. Never in HOLD.
//  - Issue at cycle T:
//    - req_ready[w]=1 and alu_en=1; alu_* are muxed combinationally from requester w.
//    - Operands are sampled by the ALU at the edge ending T.
//  - Response at T+1: BUSY, rsp_valid=1, rsp_id=w, rsp_data=alu_result.
//    - rsp_ready=1: response done; a new issue may occur at T+1. Back-to-back throughput is 1 op/cycle.
//    - rsp_ready=0: capture hold_q<=alu_result and go to HOLD.
//  - HOLD: rsp_data=hold_q, rsp_valid=1. Stay until rsp_ready=1, then go to IDLE.
//    - No issue during the rsp_ready=1 cycle either; issue resumes the following cycle.
//  - Transitions:
//    - IDLE -issue-> BUSY.
//    - BUSY & rsp_ready & issue -> BUSY.
//    - BUSY & rsp_ready & !issue -> IDLE.
//    - BUSY & !rsp_ready -> HOLD.
//    - HOLD & rsp_ready -> IDLE.
//  - No issue: alu_en=0 (ALU clears its result, which is harmless); alu_func3/cs/a/b are driven to 0.
//  - Arbitration (default round-robin):
//    - Search starts at (ptr+1) mod NREQ, wrapping; ptr<=w on each issue.
//    - With ptr=NREQ-1 after reset, requester 0 wins the first contention.
//  - req_valid may drop without a grant; no state is kept for ungranted requests.
//  - Holding req_valid=1 is not required to keep priority.
//  - req_ready depends on req_valid, state and rsp_ready only; never on req operands.
//  - Reset asserted mid-operation: any in-flight or held result is discarded and rsp_valid drops immediately.
//  - rsp_zero is computed from the selected rsp_data, not from alu.zero.
// CONFIGURATION
//  ALU_ARB_FIXED_PRIO_EN defined:
//    - strict priority, lowest index wins; ptr is not used or updated.
//    - a continuous stream from requester 0 starves all others (intended for the execute stage).
//  ALU_ARB_FIXED_PRIO_EN undefined: round-robin as above.
// TESTING
//  - Reset: rst pulse mid-BUSY with rsp_valid=1 -> rsp_valid=0 and alu_en=0 asynchronously; ptr=NREQ-1.
//  - Single op: req0 ADD a=5 b=7, rsp_ready=1 -> req_ready[0] at T; rsp at T+1 with data=12, id=0, zero=0.
//  - Contention: req0 and req1 valid every cycle, rsp_ready=1 -> grants 0,1,0,1.
//    - With ALU_ARB_FIXED_PRIO_EN: grants 0,0,0,0.
//  - Backpressure:
//    - Issue XOR a=0xFF b=0xFF, rsp_ready=0 for 3 cycles -> HOLD.
//    - rsp_data=0 and rsp_zero=1 stable; no req_ready while held.
//    - Release -> IDLE, next issue one cycle later.
//  - Back-to-back: req1 SUB (cs.sign=1) 10-3 then SLL 1<<4 on consecutive cycles -> rsp 7 then 16 on consecutive cycles, id=1.
//  - Retraction: req1 valid for one cycle while BUSY & !rsp_ready, then dropped -> never granted, no response for id 1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin (or fixed-priority, ALU_ARB_FIXED_PRIO_EN) arbiter sharing one
// registered ALU; a hold register keeps a result the winner cannot yet accept.
package alu_arbiter_pkg;
    typedef struct packed {
        logic sign;
        logic a_used;
    } control_signals_t;
endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][2:0]        req_func3,
    input  control_signals_t [NREQ-1:0] req_cs,
    input  logic [NREQ-1:0][31:0]       req_a,
    input  logic [NREQ-1:0][31:0]       req_b,
    output logic                        alu_en,
    output logic [2:0]                  alu_func3,
    output control_signals_t            alu_cs,
    output logic [31:0]                 alu_a,
    output logic [31:0]                 alu_b,
    input  logic [31:0]                 alu_result,
    output logic                        rsp_valid,
    output logic [IDW-1:0]              rsp_id,
    output logic [31:0]                 rsp_data,
    output logic                        rsp_zero,
    input  logic                        rsp_ready
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [IDW-1:0] win;
    logic [IDW-1:0] id_q;
    logic [31:0]    hold_q;
    logic           found;
    logic           can_issue;
    logic           issue;

    // Reset also blocks issue so nothing reaches the ALU while rst is high.
    assign can_issue = !rst &&
                       ((state_q == IDLE) ||
                        (state_q == BUSY && rsp_ready));
    assign issue = can_issue && found;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                win   = IDW'(k);
                found = 1'b1;
            end
        end
    end
`else
    logic [IDW-1:0] ptr_q;
    logic [IDW:0]   idx;

    // Search starts one past the last winner and wraps.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IDW'(NREQ - 1);
        end else if (issue) begin
            ptr_q <= win;
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        alu_en    = 1'b0;
        alu_func3 = '0;
        alu_cs    = '0;
        alu_a     = '0;
        alu_b     = '0;
        if (issue) begin
            req_ready[win] = 1'b1;
            alu_en         = 1'b1;
            alu_func3      = req_func3[win];
            alu_cs         = req_cs[win];
            alu_a          = req_a[win];
            alu_b          = req_b[win];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!rsp_ready) begin
                    state_d = HOLD;
                end else if (issue) begin
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The ALU clears its output once en drops, so a stalled result is saved here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                id_q <= win;
            end
            if (state_q == BUSY && !rsp_ready) begin
                hold_q <= alu_result;
            end
        end
    end

    always_comb begin
        rsp_data = '0;
        if (state_q == HOLD) begin
            rsp_data = hold_q;
        end else if (state_q == BUSY) begin
            rsp_data = alu_result;
        end
    end

    assign rsp_valid = (state_q != IDLE);
    assign rsp_id    = id_q;
    assign rsp_zero  = (rsp_data == 32'd0);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural registered ALU.
// Build with ALU_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SLL = 3'b001;
    localparam logic [2:0] F_XOR = 3'b100;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0][2:0]        req_func3;
    control_signals_t [NREQ-1:0] req_cs;
    logic [NREQ-1:0][31:0]       req_a;
    logic [NREQ-1:0][31:0]       req_b;
    logic                        alu_en;
    logic [2:0]                  alu_func3;
    control_signals_t            alu_cs;
    logic [31:0]                 alu_a;
    logic [31:0]                 alu_b;
    logic [31:0]                 alu_result;
    logic                        rsp_valid;
    logic [IDW-1:0]              rsp_id;
    logic [31:0]                 rsp_data;
    logic                        rsp_zero;
    logic                        rsp_ready;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_func3(req_func3),
        .req_cs(req_cs),
        .req_a(req_a),
        .req_b(req_b),
        .alu_en(alu_en),
        .alu_func3(alu_func3),
        .alu_cs(alu_cs),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .rsp_zero(rsp_zero),
        .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    // Registered ALU: result appears one cycle after en, zero when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result <= '0;
        end else if (!alu_en) begin
            alu_result <= '0;
        end else begin
            unique case (alu_func3)
                F_ADD:   alu_result <= alu_cs.sign ? alu_a - alu_b
                                                   : alu_a + alu_b;
                F_SLL:   alu_result <= alu_a << alu_b[4:0];
                F_XOR:   alu_result <= alu_a ^ alu_b;
                default: alu_result <= '0;
            endcase
        end
    end

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    data;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(int id, logic [31:0] data);
        exp_t e;
        e.id   = IDW'(id);
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic [2:0] f3, logic sgn,
                           logic [31:0] a, logic [31:0] b);
        req_func3[i] = f3;
        req_cs[i]    = '{sign: sgn, a_used: 1'b1};
        req_a[i]     = a;
        req_b[i]     = b;
    endtask

    // Monitor: every accepted response is matched against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL rsp_unexpected: got id %0d data %0h expected none",
                         rsp_id, rsp_data);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_zero", 32'(rsp_zero), 32'(e.data == 32'd0));
            end
        end
    end

    initial begin
        int g;
        rst       = 1'b1;
        req_valid = '0;
        req_func3 = '0;
        req_cs    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset state, with requests present
        req_valid = 2'b11;
        step();
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_alu_en", 32'(alu_en), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        step();
        rst = 1'b0;
        step();

        // Single op: 5 + 7
        set_req(0, F_ADD, 1'b0, 32'd5, 32'd7);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("single_grant", 32'(req_ready), 32'd1);
        chk("single_alu_a", alu_a, 32'd5);
        push(0, 32'd12);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        step();

        // Reset mid-BUSY while a second issue is on the ALU inputs
        set_req(1, F_ADD, 1'b0, 32'd3, 32'd4);
        req_valid = 2'b10;
        @(negedge clk);
        chk("pre_rst_grant", 32'(req_ready), 32'd2);
        push(1, 32'd7);
        step();
        req_valid = 2'b01;
        @(negedge clk);
        chk("busy_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("busy_alu_en", 32'(alu_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_alu_en", 32'(alu_en), 32'd0);
        chk("async_rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        step();
        rst = 1'b0;
        step();

        // Contention: pointer restarted at NREQ-1
        set_req(0, F_ADD, 1'b0, 32'd1, 32'd1);
        set_req(1, F_ADD, 1'b0, 32'd100, 32'd1);
        for (int c = 0; c < 4; c++) begin
            req_valid = 2'b11;
            rsp_ready = 1'b1;
            @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = c % 2;
`endif
            chk("contention_grant", 32'(req_ready), 32'(1 << g));
            push(g, (g == 1) ? 32'd101 : 32'd2);
            step();
        end
        req_valid = '0;
        @(negedge clk);
        step();

        // Backpressure: XOR gives zero, held for three cycles
        set_req(0, F_XOR, 1'b0, 32'hFF, 32'hFF);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_grant", 32'(req_ready), 32'd1);
        push(0, 32'd0);
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", rsp_data, 32'd0);
            chk("bp_rsp_zero", 32'(rsp_zero), 32'd1);
            chk("bp_no_grant", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_no_grant", 32'(req_ready), 32'd0);
        step();
        set_req(0, F_ADD, 1'b0, 32'd20, 32'd22);
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("resume_grant", 32'(req_ready), 32'd1);
        push(0, 32'd42);
        step();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("hold_rsp_data", rsp_data, 32'd42);
            chk("hold_rsp_zero", 32'(rsp_zero), 32'd0);
            chk("hold_no_grant", 32'(req_ready), 32'd0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        step();

        // Back-to-back from req1: 10-3 then 1<<4
        set_req(1, F_ADD, 1'b1, 32'd10, 32'd3);
        req_valid = 2'b10;
        @(negedge clk);
        chk("b2b_grant0", 32'(req_ready), 32'd2);
        push(1, 32'd7);
        step();
        set_req(1, F_SLL, 1'b0, 32'd1, 32'd4);
        @(negedge clk);
        chk("b2b_grant1", 32'(req_ready), 32'd2);
        push(1, 32'd16);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("b2b_second_valid", 32'(rsp_valid), 32'd1);
        step();

        // Retraction: req1 shows up for one stalled cycle only
        set_req(0, F_ADD, 1'b0, 32'd1, 32'd2);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("retract_first_grant", 32'(req_ready), 32'd1);
        push(0, 32'd3);
        step();
        set_req(1, F_ADD, 1'b0, 32'd9, 32'd9);
        req_valid = 2'b10;
        @(negedge clk);
        chk("retract_no_grant", 32'(req_ready), 32'd0);
        step();
        req_valid = '0;
        @(negedge clk);
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        step();
        repeat (3) step();
        @(negedge clk);
        chk("final_idle", 32'(rsp_valid), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
